bcd_display_mux: RTL and testbench

Time-multiplexed driver for the Basys four-digit, common-anode seven-segment display. It sits directly downstream of the binary-to-BCD converter: it captures the converter's 16-bit packed BCD result on its ready strobe and scans the four digits continuously. It applies optional leading-zero blanking, and a new value takes effect only at a frame boundary, so the display never tears.

---
 rtl/seven_seg_pkg.sv | 46 ++++
 rtl/bcd_display_mux_if.sv | 43 ++++
 rtl/seg7_decode.sv | 41 ++++
 rtl/bcd_display_mux.sv | 128 ++++++++++++
 tb/tb_bcd_display_mux.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared constants and types for the four-digit seven-segment
//                display driver. Glyphs are active-low, ordered {g,f,e,d,c,b,a}.
//                Contents:
//                  NUM_DIGITS, DIGIT_W, BCD_W   - display geometry
//                  SEG_0..SEG_9, SEG_DASH, SEG_BLANK - cathode patterns
//                  digit_e                      - scan position
//                  nibble_of()                  - nibble extraction helper
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = NUM_DIGITS * DIGIT_W;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan position; DIG_0 is the rightmost (units) digit.
    typedef enum logic [1:0] {
        DIG_0 = 2'd0,
        DIG_1 = 2'd1,
        DIG_2 = 2'd2,
        DIG_3 = 2'd3
    } digit_e;

    function automatic logic [DIGIT_W-1:0] nibble_of(input logic [BCD_W-1:0] value,
                                                      input logic [1:0]       idx);
        return value[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux_if
//  Description : Bundle between the BCD source / display pins and the
//                display multiplexer.
//                  bcd_in  [15:0]  packed BCD value          (master -> slave)
//                  bcd_vld         one-cycle valid strobe    (master -> slave)
//                  an      [3:0]   digit anodes, active-low  (slave -> master)
//                  seg     [6:0]   cathodes {g..a}, active-low
//                  dp              decimal point, active-low
//                  frame           scan-wrap pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_mux_if;
    import seven_seg_pkg::*;

    logic [BCD_W-1:0]      bcd_in;
    logic                  bcd_vld;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame;

    modport master (
        output bcd_in,
        output bcd_vld,
        input  an,
        input  seg,
        input  dp,
        input  frame
    );

    modport slave (
        input  bcd_in,
        input  bcd_vld,
        output an,
        output seg,
        output dp,
        output frame
    );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational nibble-to-glyph map for a common-anode
//                seven-segment digit. Non-BCD nibbles (A..F) render a dash.
//                  nibble_i [3:0]  digit value
//                  blank_i         force all segments off
//                  seg_o    [6:0]  cathodes {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seven_seg_pkg::*;
(
    input  wire logic [DIGIT_W-1:0] nibble_i,
    input  wire logic               blank_i,
    output logic      [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux
//  Description : Time-multiplexed driver for a four-digit common-anode
//                seven-segment display. Captures packed BCD on bcd_vld,
//                holds it pending and swaps it onto the display only at a
//                frame boundary so a frame never mixes two values.
//                Optional leading-zero blanking on digits 3..1.
//  Parameters  : REFRESH_DIV - clk cycles per lit digit (>= 2)
//                BLANK_LZ    - 1 = blank leading zeros, 0 = show all digits
//  Ports       : clk, rst_n (async, active-low)
//                bus (slave): bcd_in, bcd_vld -> an, seg, dp, frame
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bcd_display_mux_if.slave bus
);

    localparam int              PRE_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0]      pre_q,       pre_d;
    digit_e                dsel_q,      dsel_d;
    logic [BCD_W-1:0]      disp_q,      disp_d;
    logic [BCD_W-1:0]      pend_q,      pend_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [NUM_DIGITS-1:0] an_q,        an_d;
    logic [6:0]            seg_q,       seg_d;
    logic                  frame_q;

    logic                  tick;
    logic                  wrap;
    logic [NUM_DIGITS-1:0] blank_vec;
    logic [DIGIT_W-1:0]    nibble_sel;
    logic                  blank_sel;

    // ------------------------------------------------------------------
    // Prescaler, digit selector and capture / frame-update logic
    // ------------------------------------------------------------------
    always_comb begin
        tick   = (pre_q == PRE_MAX);
        pre_d  = tick ? '0 : pre_q + 1'b1;
        dsel_d = tick ? digit_e'(dsel_q + 2'd1) : dsel_q;
        wrap   = tick && (dsel_q == DIG_3);

        // Newest strobe always lands in the pending register.
        pend_d      = bus.bcd_vld ? bus.bcd_in : pend_q;
        pend_flag_d = pend_flag_q;
        disp_d      = disp_q;

        if (wrap) begin
            // A strobe coincident with the wrap bypasses the pending stage.
            if (bus.bcd_vld) begin
                disp_d = bus.bcd_in;
            end else if (pend_flag_q) begin
                disp_d = pend_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus.bcd_vld) begin
            pend_flag_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: digit k blanks when it and all higher
    // nibbles are zero. Digit 0 always shows so "0" stays visible.
    // Computed from the next-state value so the glyph and the anode
    // registered together always belong to the same digit and frame.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blank
        if (k == 0 || !BLANK_LZ) begin : g_never
            assign blank_vec[k] = 1'b0;
        end else begin : g_lz
            assign blank_vec[k] = (disp_d[BCD_W-1:k*DIGIT_W] == '0);
        end
    end

    assign nibble_sel = nibble_of(disp_d, dsel_d);
    assign blank_sel  = blank_vec[dsel_d];
    assign an_d       = ~(4'b0001 << dsel_d);

    seg7_decode u_seg7_decode (
        .nibble_i (nibble_sel),
        .blank_i  (blank_sel),
        .seg_o    (seg_d)
    );

    // ------------------------------------------------------------------
    // State and output registers. an/seg are loaded from next-state
    // selector and display values, which places the anode switch to
    // digit 0 in the same cycle as the frame pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            dsel_q      <= DIG_0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            frame_q     <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            dsel_q      <= dsel_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            frame_q     <= wrap;
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = 1'b1;
    assign bus.frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_mux
//  Description : Self-checking bench for bcd_display_mux. Two instances run
//                side by side (BLANK_LZ=1 and BLANK_LZ=0) on identical
//                stimulus and are compared every cycle against a frame-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_mux;

    localparam int R     = 4;
    localparam int FRAME = 4 * R;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_display_mux_if bus_a ();
    bcd_display_mux_if bus_b ();

    bcd_display_mux #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    bcd_display_mux #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_k     = 0;     // clock edges since reset release
    bit          m_live  = 0;     // at least one edge since release
    int          m_digit = 0;     // digit currently lit
    bit          m_frame = 0;
    logic [15:0] m_disp  = '0;
    logic [15:0] m_pend  = '0;
    bit          m_flag  = 0;

    logic [6:0] glyph [10];
    initial begin
        glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
        glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
        glyph[8] = 7'h00; glyph[9] = 7'h10;
    end

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blz);
        logic [15:0] upper;
        int          nib;
        upper = v >> (4 * d);
        nib   = int'(upper & 16'hF);
        if (blz && d > 0 && upper == 16'h0) return 7'h7F;
        if (nib > 9) return 7'h3F;
        return glyph[nib];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] e_an;
        logic [6:0] e_sa, e_sb;
        bit         e_fr;
        if (m_live) begin
            e_an = 4'hF & ~(4'b0001 << m_digit);
            e_sa = exp_seg(m_disp, m_digit, 1'b1);
            e_sb = exp_seg(m_disp, m_digit, 1'b0);
            e_fr = m_frame;
        end else begin
            e_an = 4'hF; e_sa = 7'h7F; e_sb = 7'h7F; e_fr = 1'b0;
        end
        check("an_lz",    16'(bus_a.an),    16'(e_an));
        check("seg_lz",   16'(bus_a.seg),   16'(e_sa));
        check("frame_lz", 16'(bus_a.frame), 16'(e_fr));
        check("dp_lz",    16'(bus_a.dp),    16'h1);
        check("an_all",   16'(bus_b.an),    16'(e_an));
        check("seg_all",  16'(bus_b.seg),   16'(e_sb));
        check("frame_all",16'(bus_b.frame), 16'(e_fr));
        check("dp_all",   16'(bus_b.dp),    16'h1);
    endtask

    // One clock with the given input, model update, then output check.
    task automatic step(input bit v, input logic [15:0] d);
        bit wrap;
        bus_a.bcd_vld = v; bus_a.bcd_in = d;
        bus_b.bcd_vld = v; bus_b.bcd_in = d;
        @(posedge clk);
        #1;
        if (rst_n) begin
            wrap = ((m_k + 1) % FRAME) == 0;
            if (v) begin
                m_pend = d;
                m_flag = 1;
            end
            if (wrap) begin
                if (m_flag) m_disp = m_pend;
                m_flag = 0;
            end
            m_frame = wrap;
            m_digit = ((m_k + 1) / R) % 4;
            m_live  = 1;
            m_k++;
        end
        bus_a.bcd_vld = 1'b0;
        bus_b.bcd_vld = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic until_digit(input int d);
        for (int i = 0; i < 64 && m_digit != d; i++) step(1'b0, 16'h0);
    endtask

    task automatic until_frame_start();
        for (int i = 0; i < 64 && !m_frame; i++) step(1'b0, 16'h0);
    endtask

    task automatic model_reset();
        m_k = 0; m_live = 0; m_digit = 0; m_frame = 0;
        m_disp = '0; m_pend = '0; m_flag = 0;
    endtask

    initial begin
        bus_a.bcd_vld = 1'b0; bus_a.bcd_in = '0;
        bus_b.bcd_vld = 1'b0; bus_b.bcd_in = '0;

        // Reset held: outputs at reset values
        idle(3);
        #2 rst_n = 1'b1;

        // Idle scan of value 0: two full frames
        idle(2 * FRAME);

        // Blanking: 0x0042
        step(1'b1, 16'h0042);
        idle(2 * FRAME);

        // Invalid nibble: 0x1A05
        until_digit(2);
        step(1'b1, 16'h1A05);
        idle(2 * FRAME);

        // Tear-free update while digit 1 is lit
        until_frame_start();
        until_digit(1);
        step(1'b1, 16'h1234);
        idle(2 * FRAME);

        // Overwrite within one frame: newest wins
        until_frame_start();
        idle(2);
        step(1'b1, 16'h1111);
        idle(4);
        step(1'b1, 16'h2222);
        idle(2 * FRAME);

        // Strobe coincident with wrap: immediate, pending flag clear
        for (int i = 0; i < 64 && ((m_k + 1) % FRAME) != 0; i++) step(1'b0, 16'h0);
        step(1'b1, 16'h3333);
        check("pend_flag_wrap", 16'(u_dut_a.pend_flag_q), 16'(m_flag));
        idle(FRAME + 3);

        // Reset mid-operation: load 0x9999, drop rst_n while digit 2 lit
        step(1'b1, 16'h9999);
        until_frame_start();
        until_digit(2);
        step(1'b1, 16'h5555);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        idle(2);
        #2 rst_n = 1'b1;
        idle(2 * FRAME);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] v;
            v = 16'($urandom) >> (4 * $urandom_range(0, 3));
            step(($urandom_range(0, 7) == 0), v);
        end
        idle(FRAME + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
